// File: rtl/adc_coinc_capture.sv
// Coincidence capture front end for a bank of AD7643-class serial ADCs: converts all channels
// together, shifts the results in MSB first and emits an event word when the hit pattern qualifies.
module adc_coinc_capture #(
    parameter int NCH      = 2,
    parameter int DW       = 18,
    parameter int SCLK_DIV = 2,
    parameter int CNV_W    = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DW-1:0]     THRESH,
    input  logic [NCH-1:0]    COINC_MASK,
    output logic              ADCS,
    output logic              ADCNVST,
    output logic              ADSCLK,
    input  logic [NCH-1:0]    ADBUSY,
    input  logic [NCH-1:0]    ADSDOUT,
    output logic              EVT_VALID,
    input  logic              EVT_READY,
    output logic [NCH*DW-1:0] EVT_DATA,
    output logic [NCH-1:0]    EVT_HIT,
    output logic [15:0]       FRAME_CNT,
    output logic [15:0]       DROP_CNT,
    output logic              TOUT,
    output logic [2:0]        STATE
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNV   = 3'd1,
        WAITB = 3'd2,
        SHIFT = 3'd3,
        EVAL  = 3'd4
    } state_t;

    localparam int MAX_A   = (TIMEOUT > CNV_W) ? TIMEOUT : CNV_W;
    localparam int MAX_CNT = (MAX_A > SCLK_DIV) ? MAX_A : SCLK_DIV;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int BW      = $clog2(DW + 1);

    localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_W - 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] BUSY_IGN  = CW'(2);
    localparam logic [BW-1:0] BITS      = BW'(DW);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [NCH-1:0][DW-1:0] sample;
    logic [NCH-1:0]         hit;
    logic                   qualify;

    // NOTE: every output of an always_comb gets a default first so no latch can be inferred.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++)
            hit[i] = (sample[i] >= THRESH);
        qualify = (hit != '0) && ((hit & COINC_MASK) == COINC_MASK);
    end

    assign STATE = state;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sample    <= '0;
            ADCS      <= 1'b1;
            ADCNVST   <= 1'b1;
            ADSCLK    <= 1'b0;
            EVT_VALID <= 1'b0;
            EVT_DATA  <= '0;
            EVT_HIT   <= '0;
            FRAME_CNT <= '0;
            DROP_CNT  <= '0;
            TOUT      <= 1'b0;
        end else begin
            if (EVT_VALID && EVT_READY)
                EVT_VALID <= 1'b0;

            case (state)
                IDLE: begin
                    if (START) begin
                        state   <= CNV;
                        ADCS    <= 1'b0;
                        ADCNVST <= 1'b0;
                        cnt     <= '0;
                    end
                end
                CNV: begin
                    if (cnt == CNV_LAST) begin
                        ADCNVST <= 1'b1;
                        state   <= WAITB;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAITB: begin
                    // BUSY needs two cycles to rise after the convert pulse, so ignore it until then.
                    if (cnt >= BUSY_IGN && ADBUSY == '0) begin
                        state   <= SHIFT;
                        ADSCLK  <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else if (cnt == TOUT_LAST) begin
                        TOUT  <= 1'b1;
                        ADCS  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (ADSCLK) begin
                            ADSCLK  <= 1'b0;
                            bit_cnt <= bit_cnt + BW'(1);
                            for (int i = 0; i < NCH; i++)
                                sample[i] <= {sample[i][DW-2:0], ADSDOUT[i]};
                        end else if (bit_cnt == BITS) begin
                            state <= EVAL;
                        end else begin
                            ADSCLK <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    FRAME_CNT <= FRAME_CNT + 16'd1;
                    ADCS      <= 1'b1;
                    state     <= IDLE;
                    if (qualify) begin
                        if (!EVT_VALID || EVT_READY) begin
                            EVT_VALID <= 1'b1;
                            EVT_DATA  <= sample;
                            EVT_HIT   <= hit;
                        end else if (DROP_CNT != 16'hFFFF) begin
                            DROP_CNT <= DROP_CNT + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_coinc_capture.sv
// Self-checking bench for adc_coinc_capture: behavioural ADC channels, expected events queued at
// stimulus time and popped when the DUT presents them.
module tb_adc_coinc_capture;
    localparam int NCH = 2, DW = 18, SCLK_DIV = 2, CNV_W = 3, TIMEOUT = 64;
    localparam logic [2:0] S_IDLE = 3'd0, S_CNV = 3'd1, S_WAITB = 3'd2, S_SHIFT = 3'd3, S_EVAL = 3'd4;

    typedef struct packed {
        logic [NCH*DW-1:0] data;
        logic [NCH-1:0]    hit;
    } evt_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic [DW-1:0]     THRESH = '0;
    logic [NCH-1:0]    COINC_MASK = '0;
    logic              ADCS, ADCNVST, ADSCLK;
    logic [NCH-1:0]    ADBUSY;
    logic [NCH-1:0]    ADSDOUT;
    logic              EVT_VALID;
    logic              EVT_READY = 1'b0;
    logic [NCH*DW-1:0] EVT_DATA;
    logic [NCH-1:0]    EVT_HIT;
    logic [15:0]       FRAME_CNT, DROP_CNT;
    logic              TOUT;
    logic [2:0]        STATE;

    int   tests_run = 0;
    int   tests_failed = 0;
    evt_t exp_q[$];

    logic [DW-1:0]  adc_val [NCH];
    logic [DW-1:0]  adc_sh  [NCH];
    logic [NCH-1:0] busy_stuck = '0;

    adc_coinc_capture #(
        .NCH(NCH), .DW(DW), .SCLK_DIV(SCLK_DIV), .CNV_W(CNV_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .THRESH(THRESH), .COINC_MASK(COINC_MASK),
        .ADCS(ADCS), .ADCNVST(ADCNVST), .ADSCLK(ADSCLK), .ADBUSY(ADBUSY), .ADSDOUT(ADSDOUT),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_DATA(EVT_DATA), .EVT_HIT(EVT_HIT),
        .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT), .TOUT(TOUT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // ADC data: latch the conversion on ADCNVST fall, present the next bit after each ADSCLK fall.
    initial begin
        for (int i = 0; i < NCH; i++) adc_sh[i] = '0;
        forever begin
            @(negedge ADCNVST or negedge ADSCLK);
            for (int i = 0; i < NCH; i++)
                adc_sh[i] = (!ADCNVST) ? adc_val[i] : (adc_sh[i] << 1);
        end
    end

    always_comb begin
        ADSDOUT = '0;
        for (int i = 0; i < NCH; i++) ADSDOUT[i] = adc_sh[i][DW-1];
    end

    // ADC busy: high from the convert pulse for a few cycles, then settles to busy_stuck.
    initial begin
        ADBUSY = '0;
        forever begin
            @(negedge ADCNVST);
            ADBUSY = '1;
            repeat (CNV_W + 4) @(posedge CLK);
            #1 ADBUSY = busy_stuck;
        end
    end

    int   cnvst_low = 0, sclk_high = 0, sclk_rise = 0, shift_cyc = 0, waitb_cyc = 0;
    logic sclk_prev = 1'b0;
    always @(negedge CLK) begin
        if (ADCNVST === 1'b0) cnvst_low++;
        if (ADSCLK === 1'b1) sclk_high++;
        if (ADSCLK === 1'b1 && sclk_prev !== 1'b1) sclk_rise++;
        sclk_prev = ADSCLK;
        if (STATE === S_SHIFT) shift_cyc++;
        if (STATE === S_WAITB) waitb_cyc++;
    end

    function automatic logic [NCH-1:0] model_hit(input logic [DW-1:0] d0, d1, th);
        return {d1 >= th, d0 >= th};
    endfunction

    function automatic bit model_qual(input logic [NCH-1:0] h, m);
        return (h != '0) && ((h & m) == m);
    endfunction

    task automatic expect_frame(input logic [DW-1:0] d0, d1, th, input logic [NCH-1:0] m);
        evt_t e;
        e.data = {d1, d0};
        e.hit  = model_hit(d0, d1, th);
        if (model_qual(e.hit, m)) exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge CLK);
            seen = (STATE === s);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: STATE=%0d, wanted %0d within %0d cycles", tag, STATE, s, budget);
        end
    endtask

    task automatic consume(input string tag);
        evt_t e;
        @(negedge CLK);
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: no expected event queued, EVT_VALID=%b", tag, EVT_VALID);
            return;
        end
        e = exp_q.pop_front();
        if (EVT_VALID !== 1'b1 || EVT_DATA !== e.data || EVT_HIT !== e.hit) begin
            tests_failed++;
            $display("FAIL %s: valid=%b data=%h hit=%b, wanted valid=1 data=%h hit=%b",
                     tag, EVT_VALID, EVT_DATA, EVT_HIT, e.data, e.hit);
        end
        @(posedge CLK); #1 EVT_READY = 1'b1;
        @(posedge CLK); #1 EVT_READY = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (EVT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_clear: EVT_VALID=%b after accept, wanted 0", tag, EVT_VALID);
        end
    endtask

    task automatic set_frame(input logic [DW-1:0] d0, d1, th, input logic [NCH-1:0] m);
        adc_val[0] = d0;
        adc_val[1] = d1;
        THRESH     = th;
        COINC_MASK = m;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({ADCS, ADCNVST, ADSCLK, EVT_VALID, EVT_DATA, EVT_HIT, FRAME_CNT, DROP_CNT, TOUT, STATE}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 36'h0, 2'b00, 16'h0, 16'h0, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_vals: cs=%b cnv=%b sclk=%b v=%b d=%h h=%b fc=%h dc=%h to=%b st=%0d",
                     ADCS, ADCNVST, ADSCLK, EVT_VALID, EVT_DATA, EVT_HIT, FRAME_CNT, DROP_CNT, TOUT, STATE);
        end
        @(posedge CLK); #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        tests_run++;
        if (STATE !== S_IDLE || ADCS !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_no_start: STATE=%0d ADCS=%b, wanted 0/1", STATE, ADCS);
        end
    endtask

    task automatic test_single_event();
        int c_low, c_high, c_rise, c_shift;
        bit stayed = 1'b1;
        @(posedge CLK); #1;
        set_frame(18'h20000, 18'h00010, 18'h10000, 2'b01);
        expect_frame(18'h20000, 18'h00010, 18'h10000, 2'b01);
        c_low = cnvst_low; c_high = sclk_high; c_rise = sclk_rise; c_shift = shift_cyc;
        START = 1'b1;
        wait_state(S_SHIFT, 40, "single_to_shift");
        START = 1'b0;
        wait_state(S_EVAL, 100, "single_to_eval");
        wait_state(S_IDLE, 4, "single_to_idle");
        tests_run++;
        if (FRAME_CNT !== 16'd1) begin
            tests_failed++; $display("FAIL single_frame_cnt: got %0d, wanted 1", FRAME_CNT);
        end
        tests_run++;
        if (cnvst_low - c_low !== 3) begin
            tests_failed++; $display("FAIL cnvst_width: got %0d cycles, wanted 3", cnvst_low - c_low);
        end
        tests_run++;
        if (sclk_rise - c_rise !== DW) begin
            tests_failed++; $display("FAIL sclk_periods: got %0d, wanted %0d", sclk_rise - c_rise, DW);
        end
        tests_run++;
        if (sclk_high - c_high !== DW * SCLK_DIV) begin
            tests_failed++; $display("FAIL sclk_high: got %0d, wanted %0d", sclk_high - c_high, DW * SCLK_DIV);
        end
        tests_run++;
        if (shift_cyc - c_shift !== DW * 2 * SCLK_DIV) begin
            tests_failed++; $display("FAIL shift_len: got %0d, wanted %0d", shift_cyc - c_shift, DW * 2 * SCLK_DIV);
        end
        consume("single_event");
        repeat (5) begin
            @(negedge CLK);
            if (STATE !== S_IDLE || ADCS !== 1'b1) stayed = 1'b0;
        end
        tests_run++;
        if (!stayed) begin
            tests_failed++; $display("FAIL start_dropped_idle: STATE=%0d ADCS=%b, wanted IDLE/1", STATE, ADCS);
        end
    endtask

    task automatic test_coinc_reject();
        @(posedge CLK); #1;
        set_frame(18'h20000, 18'h00010, 18'h10000, 2'b11);
        expect_frame(18'h20000, 18'h00010, 18'h10000, 2'b11);
        START = 1'b1;
        wait_state(S_CNV, 4, "reject_to_cnv");
        START = 1'b0;
        wait_state(S_EVAL, 120, "reject_to_eval");
        wait_state(S_IDLE, 4, "reject_to_idle");
        @(negedge CLK);
        tests_run++;
        if (EVT_VALID !== (exp_q.size() != 0) || FRAME_CNT !== 16'd2 || DROP_CNT !== 16'd0) begin
            tests_failed++;
            $display("FAIL coinc_reject: valid=%b fc=%0d dc=%0d, wanted valid=0 fc=2 dc=0",
                     EVT_VALID, FRAME_CNT, DROP_CNT);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        set_frame(18'h3FFFF, 18'h10000, 18'h10000, 2'b11);
        expect_frame(18'h3FFFF, 18'h10000, 18'h10000, 2'b11);
        START = 1'b1;
        wait_state(S_CNV, 4, "b2b_a_cnv");
        adc_val[0] = 18'h12345;
        adc_val[1] = 18'h00001;
        wait_state(S_EVAL, 120, "b2b_a_eval");
        wait_state(S_IDLE, 4, "b2b_a_idle");
        tests_run++;
        if (ADCS !== 1'b1) begin
            tests_failed++; $display("FAIL cs_gap: ADCS=%b between frames, wanted 1", ADCS);
        end
        COINC_MASK = 2'b00;
        wait_state(S_CNV, 2, "b2b_b_cnv");
        START = 1'b0;
        wait_state(S_EVAL, 120, "b2b_b_eval");
        wait_state(S_IDLE, 4, "b2b_b_idle");
        @(negedge CLK);
        tests_run++;
        if (EVT_VALID !== 1'b1 || EVT_DATA !== {18'h10000, 18'h3FFFF} || EVT_HIT !== 2'b11) begin
            tests_failed++;
            $display("FAIL held_event: v=%b d=%h h=%b, wanted 1 %h 11",
                     EVT_VALID, EVT_DATA, EVT_HIT, {18'h10000, 18'h3FFFF});
        end
        tests_run++;
        if (DROP_CNT !== 16'd1 || FRAME_CNT !== 16'd4) begin
            tests_failed++; $display("FAIL drop_cnt: dc=%0d fc=%0d, wanted 1/4", DROP_CNT, FRAME_CNT);
        end
        consume("b2b_first_event");
    endtask

    task automatic test_timeout();
        int c_wait;
        @(posedge CLK); #1;
        set_frame(18'h00000, 18'h00000, 18'h10000, 2'b00);
        busy_stuck = 2'b10;
        c_wait = waitb_cyc;
        START = 1'b1;
        wait_state(S_WAITB, 10, "tout_to_waitb");
        wait_state(S_IDLE, 80, "tout_to_idle");
        tests_run++;
        if (waitb_cyc - c_wait !== TIMEOUT) begin
            tests_failed++; $display("FAIL tout_len: WAITB %0d cycles, wanted %0d", waitb_cyc - c_wait, TIMEOUT);
        end
        tests_run++;
        if (TOUT !== 1'b1 || ADCS !== 1'b1 || FRAME_CNT !== 16'd4 || EVT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL tout_flags: to=%b cs=%b fc=%0d v=%b, wanted 1 1 4 0", TOUT, ADCS, FRAME_CNT, EVT_VALID);
        end
        busy_stuck = 2'b00;
        wait_state(S_CNV, 3, "tout_restart");
        START = 1'b0;
        wait_state(S_EVAL, 120, "tout_next_eval");
        wait_state(S_IDLE, 4, "tout_next_idle");
        tests_run++;
        if (FRAME_CNT !== 16'd5 || TOUT !== 1'b1 || EVT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL tout_sticky: fc=%0d to=%b v=%b, wanted 5 1 0", FRAME_CNT, TOUT, EVT_VALID);
        end
    endtask

    task automatic test_reset_mid_shift();
        @(posedge CLK); #1;
        set_frame(18'h20000, 18'h00010, 18'h10000, 2'b01);
        expect_frame(18'h20000, 18'h00010, 18'h10000, 2'b01);
        START = 1'b1;
        wait_state(S_CNV, 4, "rst_held_cnv");
        wait_state(S_SHIFT, 40, "rst_to_shift");
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        #1;
        exp_q.delete();
        tests_run++;
        if ({ADCS, ADCNVST, ADSCLK, EVT_VALID, EVT_DATA, EVT_HIT, FRAME_CNT, DROP_CNT, TOUT, STATE}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 36'h0, 2'b00, 16'h0, 16'h0, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: cs=%b cnv=%b sclk=%b v=%b d=%h h=%b fc=%h dc=%h to=%b st=%0d",
                     ADCS, ADCNVST, ADSCLK, EVT_VALID, EVT_DATA, EVT_HIT, FRAME_CNT, DROP_CNT, TOUT, STATE);
        end
        @(posedge CLK); #1 RST = 1'b0;
        expect_frame(18'h20000, 18'h00010, 18'h10000, 2'b01);
        @(negedge CLK);
        @(negedge CLK);
        tests_run++;
        if (STATE !== S_CNV || ADCS !== 1'b0) begin
            tests_failed++; $display("FAIL resume: STATE=%0d ADCS=%b, wanted 1/0", STATE, ADCS);
        end
        START = 1'b0;
        wait_state(S_EVAL, 120, "resume_eval");
        wait_state(S_IDLE, 4, "resume_idle");
        consume("resume_event");
        tests_run++;
        if (FRAME_CNT !== 16'd1 || DROP_CNT !== 16'd0) begin
            tests_failed++; $display("FAIL resume_cnt: fc=%0d dc=%0d, wanted 1/0", FRAME_CNT, DROP_CNT);
        end
    endtask

    initial begin
        adc_val[0] = '0;
        adc_val[1] = '0;
        test_reset();
        test_single_event();
        test_coinc_reject();
        test_back_to_back();
        test_timeout();
        test_reset_mid_shift();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL leftover_events: %0d expected events never seen", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
